// File: rtl/iterative_shifter.sv
// -----------------------------------------------------------------------------
// iterative_shifter
//
// Purpose:
//   Multi-cycle barrel-shifter replacement. An accepted start captures the
//   operand and control bits, then the working register is shifted by one bit
//   per clock until the requested count is exhausted. The final value is
//   copied to a registered result together with a one-cycle done pulse.
//
// Optional feature:
//   SHIFTER_ROTATE_EN - when defined, rot=1 turns each single-bit step into a
//                       rotate (left: MSB -> LSB, right: LSB -> MSB, arith
//                       ignored). When undefined, rot is captured but has no
//                       effect, so behaviour equals rot=0.
//
// Ports:
//   clk      in   1        clock, rising edge
//   rst_n    in   1        synchronous active-low reset
//   start    in   1        request an operation (sampled in IDLE only)
//   data_in  in   WIDTH    operand
//   shamt    in   SHAMT_W  shift count
//   dir      in   1        0 = left, 1 = right
//   arith    in   1        1 = arithmetic right shift
//   rot      in   1        1 = rotate (see SHIFTER_ROTATE_EN)
//   busy     out  1        operation in progress (state != IDLE)
//   done     out  1        one-cycle pulse, result valid
//   result   out  WIDTH    registered shifted value
//
// Timing (start accepted at edge 0):
//   edges 1..shamt shift the working register, the edge leaving DONE
//   (edge shamt+1) loads result and raises done, so done is high in the first
//   IDLE cycle after the operation. busy covers shamt+1 cycles.
//
// State table:
//   state    | meaning
//   ST_IDLE  | waiting for start; operands captured on start
//   ST_SHIFT | one single-bit step per cycle, counter decrements
//   ST_DONE  | working register complete; result/done loaded on exit
// -----------------------------------------------------------------------------
module iterative_shifter #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               dir,
    input  logic               arith,
    input  logic               rot,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

`ifdef SHIFTER_ROTATE_EN
    localparam logic ROT_EN = 1'b1;
`else
    localparam logic ROT_EN = 1'b0;
`endif

    localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};
    localparam logic [SHAMT_W-1:0] CNT_ZERO = '0;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_work;
    logic [SHAMT_W-1:0] r_cnt;
    logic               r_dir;
    logic               r_arith;
    logic               r_rot;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;

    logic               w_rot_active;
    logic               w_fill_l;
    logic               w_fill_r;
    logic [WIDTH-1:0]   w_step;
    logic               w_accept;

    // rot is always captured; it only influences the data path when the
    // rotate feature is compiled in.
    assign w_rot_active = r_rot & ROT_EN;
    assign w_accept     = (r_state == ST_IDLE) && start;

    // Bit shifted in at the vacated end for a single step.
    always_comb begin
        w_fill_l = 1'b0;
        w_fill_r = 1'b0;
        if (w_rot_active) begin
            w_fill_l = r_work[WIDTH-1];
            w_fill_r = r_work[0];
        end else if (r_arith) begin
            w_fill_r = r_work[WIDTH-1];
        end
    end

    always_comb begin
        w_step = r_work;
        if (r_dir) begin
            w_step = {w_fill_r, r_work[WIDTH-1:1]};
        end else begin
            w_step = {r_work[WIDTH-2:0], w_fill_l};
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    // A zero count skips SHIFT; the operand passes straight through.
                    w_state_nxt = (shamt == CNT_ZERO) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == CNT_ONE) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Data path: operand capture, stepping, result/done registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_work   <= '0;
            r_cnt    <= '0;
            r_dir    <= 1'b0;
            r_arith  <= 1'b0;
            r_rot    <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_work  <= data_in;
                r_cnt   <= shamt;
                r_dir   <= dir;
                r_arith <= arith;
                r_rot   <= rot;
            end else if (r_state == ST_SHIFT) begin
                r_work <= w_step;
                r_cnt  <= r_cnt - CNT_ONE;
            end else if (r_state == ST_DONE) begin
                // result is only touched here, so it holds across SHIFT.
                r_result <= r_work;
                r_done   <= 1'b1;
            end
        end
    end

    assign busy   = (r_state != ST_IDLE);
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_iterative_shifter.sv
module tb_iterative_shifter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] data_in;
    logic [3:0]  shamt;
    logic        dir;
    logic        arith;
    logic        rot;
    logic        busy;
    logic        done;
    logic [15:0] result;

    int errors = 0;
    int checks = 0;
    int done_seen = 0;
    int ops_issued = 0;
    logic [15:0] exp_q[$];

    iterative_shifter #(.WIDTH(16), .SHAMT_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .data_in (data_in),
        .shamt   (shamt),
        .dir     (dir),
        .arith   (arith),
        .rot     (rot),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every done pulse pops one expected result.
    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: result=%0h with no operation pending", result);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    if (result !== e) begin
                        errors++;
                        $display("FAIL result: got %0h, expected %0h", result, e);
                    end
                end
            end
        end
    end

    // Issue one operation and watch its timing. spur >= 0 pulses a second
    // start (with different data) during that busy cycle, which must be ignored.
    task automatic run_op(input logic [15:0] d, input logic [3:0] sh, input logic dr,
                          input logic ar, input logic rt, input logic [15:0] exp_res,
                          input int spur, input string name);
        int k;
        int dcyc;
        int bcnt;
        bit seen;
        bit held;
        logic [15:0] r0;
        @(negedge clk);
        data_in = d; shamt = sh; dir = dr; arith = ar; rot = rt; start = 1'b1;
        exp_q.push_back(exp_res);
        ops_issued++;
        r0 = result;
        k = 0; dcyc = -1; bcnt = 0; seen = 0; held = 1;
        while (!seen && k < 60) begin
            @(negedge clk);
            start = 1'b0;
            data_in = ~d; shamt = ~sh; dir = ~dr; arith = ~ar; rot = ~rt;
            if (done === 1'b1) begin
                seen = 1;
                dcyc = k;
            end
            if (busy === 1'b1) begin
                bcnt++;
                if (result !== r0) held = 0;
            end
            if (k == spur) begin
                start = 1'b1;
                data_in = 16'hFFFF;
                shamt = 4'd0;
            end
            k++;
        end
        start = 1'b0;
        if (!seen) $display("FAIL %s_timeout: no done within 60 cycles", name);
        check({name, "_done_cycle"}, dcyc, sh + 1);
        check({name, "_busy_cycles"}, bcnt, sh + 1);
        check({name, "_result_held"}, held, 1);
    endtask

    initial begin
        logic [15:0] exp_rot_l;
        logic [15:0] exp_rot_r;
        int dn;
`ifdef SHIFTER_ROTATE_EN
        exp_rot_l = 16'h0003;
        exp_rot_r = 16'h8000;
`else
        exp_rot_l = 16'h0002;
        exp_rot_r = 16'h0000;
`endif
        rst_n = 1'b0; start = 1'b0; data_in = '0; shamt = '0;
        dir = 1'b0; arith = 1'b0; rot = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        rst_n = 1'b1;

        run_op(16'h0001, 4'd15, 1'b0, 1'b0, 1'b0, 16'h8000, 5,  "left15");
        run_op(16'h8000, 4'd4,  1'b1, 1'b1, 1'b0, 16'hF800, -1, "asr4");
        run_op(16'h8000, 4'd4,  1'b1, 1'b0, 1'b0, 16'h0800, 2,  "lsr4");
        run_op(16'hA5A5, 4'd0,  1'b0, 1'b0, 1'b0, 16'hA5A5, 0,  "zero");
        run_op(16'h1234, 4'd4,  1'b0, 1'b1, 1'b0, 16'h2340, -1, "left4_arith_ign");
        run_op(16'h1234, 4'd3,  1'b1, 1'b0, 1'b0, 16'h0246, -1, "lsr3");
        run_op(16'hF0F0, 4'd15, 1'b1, 1'b1, 1'b0, 16'hFFFF, -1, "asr15");
        run_op(16'h8001, 4'd1,  1'b0, 1'b0, 1'b1, exp_rot_l, -1, "rot_left");
        run_op(16'h0001, 4'd1,  1'b1, 1'b1, 1'b1, exp_rot_r, -1, "rot_right");

        // Reset mid-SHIFT: accepted at edge 0, reset sampled at edge 3.
        @(negedge clk);
        data_in = 16'h00FF; shamt = 4'd8; dir = 1'b0; arith = 1'b0; rot = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort_busy_before_reset", busy, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_result", result, 0);
        check("abort_done", done, 0);
        rst_n = 1'b1;
        dn = done_seen;
        repeat (15) @(negedge clk);
        check("abort_no_done", done_seen - dn, 0);

        // Fresh operation after the abort still works.
        run_op(16'h00FF, 4'd8, 1'b0, 1'b0, 1'b0, 16'hFF00, -1, "after_abort");

        repeat (3) @(negedge clk);
        check("done_pulse_count", done_seen, ops_issued);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iterative_shifter.md
ITERATIVE_SHIFTER -- requirements
Module: iterative_shifter

Interface
REQ-001 Parameter: WIDTH, 16, data path width in bits.
REQ-002 Parameter: SHAMT_W, 4, shift-amount width in bits; the maximum shift is 2^SHAMT_W-1.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst_n  input  1  reset; synchronous, active-low.
REQ-005 Port: start  input  1  request a shift operation; sampled only in IDLE.
REQ-006 Port: data_in  input  WIDTH  operand; captured on the accepted start.
REQ-007 Port: shamt  input  SHAMT_W  shift count; captured on the accepted start.
REQ-008 Port: dir  input  1  0 = left, 1 = right; captured on the accepted start.
REQ-009 Port: arith  input  1  1 = arithmetic right shift (MSB replicated); ignored when dir=0; captured on the accepted start.
REQ-010 Port: rot  input  1  1 = rotate instead of shift; active only when SHIFTER_ROTATE_EN is defined.
REQ-011 Port: busy  output  1  high while an operation is in progress (state != IDLE).
REQ-012 Port: done  output  1  one-cycle pulse; result is valid.
REQ-013 Port: result  output  WIDTH  shifted value; registered.

Function
REQ-014 The block SHALL implement a 3-state FSM: IDLE, SHIFT, DONE.
REQ-015 In IDLE with start=1, the block SHALL capture data_in into the working register and capture shamt, dir, arith and rot; a start in any other state SHALL be ignored.
REQ-016 On the accepted start, the FSM SHALL go to DONE if shamt=0, and to SHIFT otherwise.
REQ-017 In SHIFT, each cycle SHALL perform exactly one single-bit shift of the working register and decrement the counter; the FSM SHALL go to DONE on the cycle the counter goes from 1 to 0.
REQ-018 A left shift SHALL fill the LSB with 0.
REQ-019 A logical right shift SHALL fill the MSB with 0.
REQ-020 An arithmetic right shift SHALL fill the MSB with the current MSB.
REQ-021 In DONE, the block SHALL drive done=1 for exactly one cycle, drive result with the working register, and go to IDLE on the next edge.
REQ-022 Latency: with start accepted at edge 0, done SHALL be high during the cycle following edge shamt+1; the total is shamt+2 cycles from start to return to IDLE.
REQ-023 result SHALL hold its value from DONE until the next DONE; it SHALL NOT change during SHIFT.
REQ-024 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-025 A start asserted in the same cycle as DONE SHALL be ignored; back-to-back operations SHALL have a minimum gap of one IDLE cycle.
REQ-026 Captured operands SHALL NOT be affected by input changes after acceptance.

Reset
REQ-027 When rst_n=0 at a clock edge, the FSM SHALL go to IDLE, and busy, done, result, the working register and the counter SHALL all become 0.
REQ-028 Reset SHALL take priority over start and over any operation in progress; an aborted operation SHALL produce no done pulse.

Configuration
REQ-029 With SHIFTER_ROTATE_EN defined and rot=1, each single-bit step SHALL rotate: left moves the MSB into the LSB, right moves the LSB into the MSB, and arith is ignored.
REQ-030 Without SHIFTER_ROTATE_EN, rot SHALL be ignored, and behaviour SHALL be identical to rot=0.

Verification
REQ-031 Reset mid-SHIFT: data_in=16'h00FF, shamt=8, dir=0; assert rst_n=0 at cycle 3 -> busy=0, result=0, and no done pulse.
REQ-032 Left shift: data_in=16'h0001, shamt=15, dir=0 -> done in cycle 16 after start, result=16'h8000, busy high for 16 cycles.
REQ-033 Arithmetic right shift: data_in=16'h8000, shamt=4, dir=1, arith=1 -> result=16'hF800; with arith=0 -> result=16'h0800.
REQ-034 Zero shift and ignored start: data_in=16'hA5A5, shamt=0 -> done one cycle after start, result=16'hA5A5; a second start pulsed while busy -> ignored, exactly one done pulse.
REQ-035 Rotate (SHIFTER_ROTATE_EN defined): data_in=16'h8001, shamt=1, dir=0, rot=1 -> result=16'h0003; without the macro -> result=16'h0002.
